// File: rtl/im_burst.sv
// im_burst: word-addressed on-chip memory with byte-enabled writes,
// configurable read wait states, incrementing read bursts, valid/ready
// handshakes on request and response, and a one-word-per-cycle clear sweep
// after reset.
module im_burst #(
  parameter int data_size    = 32,
  parameter int mem_size     = 1024,
  parameter int mem_size_bit = 10,
  parameter int wait_states  = 1,
  parameter int burst_bit    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [mem_size_bit-1:0]   req_address,
  input  logic [burst_bit-1:0]      req_burst,
  input  logic [data_size-1:0]      req_wdata,
  input  logic [data_size/8-1:0]    req_byte_en,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [data_size-1:0]      rsp_data,
  output logic                      rsp_last,
  output logic                      busy
);

  localparam int unsigned byte_count = data_size / 8;
  localparam logic [mem_size_bit-1:0] last_addr = mem_size_bit'(mem_size - 1);
  localparam logic [burst_bit:0] one_beat  = (burst_bit+1)'(1);
  localparam logic [burst_bit:0] two_beats = (burst_bit+1)'(2);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, BURST} state_t;

  state_t state, state_next;

  logic [data_size-1:0]    mem [mem_size];
  logic [mem_size_bit-1:0] clr_addr;
  logic [mem_size_bit-1:0] addr;
  logic [mem_size_bit-1:0] addr_inc;
  logic [burst_bit:0]      beats;
  logic [2:0]              wait_cnt;
  logic                    accept;
  logic                    read_accept;
  logic                    write_accept;

  assign req_ready    = (state == IDLE);
  assign busy         = (state == CLEAR);
  assign accept       = req_valid && req_ready;
  assign read_accept  = accept && !req_write;
  assign write_accept = accept && req_write;
  // Natural wrap of the address width gives the mem_size-1 -> 0 rollover.
  assign addr_inc     = addr + 1'b1;

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clock) begin
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clr_addr == last_addr) state_next = IDLE;
      IDLE:  if (read_accept) state_next = WAIT;
      WAIT:  if (wait_cnt == 3'd0) state_next = BURST;
      BURST: if (rsp_ready && rsp_last) state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Memory array: clear sweep writes and byte-enabled request writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (write_accept) begin
        for (int unsigned i = 0; i < byte_count; i++) begin
          if (req_byte_en[i]) mem[req_address][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read datapath: address/beat/wait counters and the response register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clr_addr  <= '0;
      addr      <= '0;
      beats     <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        CLEAR: clr_addr <= clr_addr + 1'b1;
        IDLE: begin
          if (read_accept) begin
            addr     <= req_address;
            beats    <= {1'b0, req_burst} + 1'b1;
            wait_cnt <= 3'(wait_states);
          end
        end
        WAIT: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else begin
            rsp_data  <= mem[addr];
            rsp_valid <= 1'b1;
            rsp_last  <= (beats == one_beat);
          end
        end
        BURST: begin
          if (rsp_ready) begin
            if (!rsp_last) begin
              addr     <= addr_inc;
              rsp_data <= mem[addr_inc];
              beats    <= beats - 1'b1;
              rsp_last <= (beats == two_beats);
            end else begin
              rsp_valid <= 1'b0;
              rsp_last  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_burst.sv
// tb_im_burst: scoreboard-based bench for im_burst with default parameters.
module tb_im_burst;

  localparam int DW = 32;
  localparam int MS = 1024;
  localparam int MB = 10;
  localparam int WS = 1;
  localparam int BB = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [MB-1:0] req_address = '0;
  logic [BB-1:0] req_burst = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW/8-1:0] req_byte_en = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;

  im_burst #(
    .data_size(DW), .mem_size(MS), .mem_size_bit(MB),
    .wait_states(WS), .burst_bit(BB)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_burst(req_burst), .req_wdata(req_wdata),
    .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    tests_run = 0;
  int    tests_failed = 0;
  int    accepts = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Response monitor: scoreboard pop on each handshake, stall stability check.
  always @(negedge clock) begin
    if (reset && prev_stall) begin
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_last !== prev_last) begin
        tests_failed++;
        $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                 rsp_valid, rsp_data, rsp_last, prev_data, prev_last);
      end
    end
    if (reset && req_valid && req_ready) accepts++;
    if (reset && rsp_valid === 1'b1 && rsp_ready) begin
      beat_t e;
      tests_run++;
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_beat: got data=%h last=%b, need no beat", rsp_data, rsp_last);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_last !== e.last) begin
          tests_failed++;
          $display("FAIL beat: got data=%h last=%b, need data=%h last=%b",
                   rsp_data, rsp_last, e.data, e.last);
        end
      end
    end
    prev_stall = reset && (rsp_valid === 1'b1) && !rsp_ready;
    prev_data  = rsp_data;
    prev_last  = rsp_last;
  end

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    beat_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Offer a request until accepted; returns the edge index of acceptance.
  task automatic issue(input logic wr, input logic [MB-1:0] a, input logic [BB-1:0] b,
                       input logic [DW-1:0] d, input logic [DW/8-1:0] be, output int acc);
    bit got;
    got = 1'b0;
    req_write = wr; req_address = a; req_burst = b; req_wdata = d; req_byte_en = be;
    req_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (req_ready === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      tests_run++; tests_failed++;
      $display("FAIL issue_timeout: got req_ready=%b, need 1", req_ready);
      req_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clock); #1;
      acc = cyc;
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && req_ready === 1'b1) break;
    end
    tests_run++;
    if (exp_q.size() != 0 || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain: got pending=%0d req_ready=%b, need pending=0 req_ready=1",
               exp_q.size(), req_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (busy === 1'b1) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n, k;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_last !== 1'b0 ||
        rsp_data !== '0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b valid=%b last=%b data=%h busy=%b, need 0 0 0 0 1",
               req_ready, rsp_valid, rsp_last, rsp_data, busy);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    wait_clear(n);
    tests_run++;
    if (n != MS) begin
      tests_failed++;
      $display("FAIL clear_length: got %0d busy cycles, need %0d", n, MS);
    end
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_clear: got %b, need 1", req_ready);
    end
    @(posedge clock); #1;
    expect_beat('0, 1'b1);
    issue(1'b0, 10'd5, 2'd0, '0, '0, k);
    drain();
  endtask

  task automatic test_byte_write();
    int k, j;
    issue(1'b1, 10'd3, 2'd0, 32'hDEADBEEF, 4'b1111, k);
    issue(1'b1, 10'd3, 2'd0, 32'h000000AA, 4'b0001, k);
    expect_beat(32'hDEADBEAA, 1'b1);
    issue(1'b0, 10'd3, 2'd0, '0, '0, k);
    j = -1;
    if (rsp_valid === 1'b1) j = cyc;
    for (int i = 0; i < 20 && j < 0; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) j = cyc;
    end
    tests_run++;
    if (j != k + 1 + WS) begin
      tests_failed++;
      $display("FAIL read_latency: got first beat after edge %0d, need %0d", j, k + 1 + WS);
    end
    drain();
    issue(1'b1, 10'd3, 2'd0, 32'hFFFFFFFF, 4'b0000, k);
    expect_beat(32'hDEADBEAA, 1'b1);
    issue(1'b0, 10'd3, 2'd0, '0, '0, k);
    drain();
  endtask

  task automatic write_wrap_words();
    int k;
    issue(1'b1, 10'd1022, 2'd0, 32'h11, 4'hF, k);
    issue(1'b1, 10'd1023, 2'd0, 32'h22, 4'hF, k);
    issue(1'b1, 10'd0,    2'd0, 32'h33, 4'hF, k);
    issue(1'b1, 10'd1,    2'd0, 32'h44, 4'hF, k);
  endtask

  task automatic push_wrap_beats();
    expect_beat(32'h11, 1'b0);
    expect_beat(32'h22, 1'b0);
    expect_beat(32'h33, 1'b0);
    expect_beat(32'h44, 1'b1);
  endtask

  task automatic test_burst_wrap();
    int k;
    bit seen;
    write_wrap_words();
    rsp_ready = 1'b1;
    beat_cyc.delete();
    push_wrap_beats();
    issue(1'b0, 10'd1022, 2'd3, '0, '0, k);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1 && rsp_last === 1'b1) begin seen = 1'b1; break; end
    end
    @(negedge clock);
    tests_run++;
    if (!seen || req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL turnaround: got last_seen=%b req_ready=%b, need 1 1", seen, req_ready);
    end
    tests_run++;
    if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3) begin
      tests_failed++;
      $display("FAIL burst_rate: got %0d beats span %0d, need 4 beats span 3",
               beat_cyc.size(), beat_cyc.size() == 4 ? beat_cyc[3] - beat_cyc[0] : -1);
    end
    drain();
  endtask

  task automatic test_stall();
    int k;
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rsp_ready = 1'b0;
    beat_cyc.delete();
    push_wrap_beats();
    issue(1'b0, 10'd1022, 2'd3, '0, '0, k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) break;
    end
    @(posedge clock); #1;
    for (int i = 0; i < 7; i++) begin
      rsp_ready = pat[i];
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    drain();
    tests_run++;
    if (beat_cyc.size() != 4) begin
      tests_failed++;
      $display("FAIL stall_beats: got %0d beats, need 4", beat_cyc.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    int k, n;
    logic [MB-1:0] addrs [5] = '{10'd1022, 10'd1023, 10'd0, 10'd1, 10'd3};
    rsp_ready = 1'b1;
    expect_beat(32'h11, 1'b0);
    issue(1'b0, 10'd1022, 2'd3, '0, '0, k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) break;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_abort: got valid=%b busy=%b ready=%b, need 0 1 0",
               rsp_valid, busy, req_ready);
    end
    wait_clear(n);
    tests_run++;
    if (n != MS - 1) begin
      tests_failed++;
      $display("FAIL reclear_length: got %0d more busy cycles, need %0d", n, MS - 1);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      expect_beat('0, 1'b1);
      issue(1'b0, addrs[i], 2'd0, '0, '0, k);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int k1, k2, a0;
    rsp_ready = 1'b1;
    issue(1'b1, 10'd7, 2'd0, 32'h77, 4'hF, k1);
    issue(1'b1, 10'd8, 2'd0, 32'h88, 4'hF, k2);
    tests_run++;
    if (k2 != k1 + 1) begin
      tests_failed++;
      $display("FAIL write_back_to_back: got gap %0d, need 1", k2 - k1);
    end
    issue(1'b1, 10'd9, 2'd0, 32'h99, 4'hF, k1);
    a0 = accepts;
    expect_beat(32'h77, 1'b0);
    expect_beat(32'h88, 1'b1);
    issue(1'b0, 10'd7, 2'd1, '0, '0, k1);
    expect_beat(32'h99, 1'b1);
    issue(1'b0, 10'd9, 2'd0, '0, '0, k2);
    tests_run++;
    if (k2 - k1 != 1 + WS + 2 + 1) begin
      tests_failed++;
      $display("FAIL held_request_gap: got %0d, need %0d", k2 - k1, 1 + WS + 2 + 1);
    end
    drain();
    tests_run++;
    if (accepts - a0 != 2) begin
      tests_failed++;
      $display("FAIL accept_count: got %0d, need 2", accepts - a0);
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_burst_wrap();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: got %0d pending, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/im_burst.md
# im_burst

Parametrised successor to the single-port instruction memory: a synchronous word-addressed memory with byte-enabled writes, configurable read wait states, multi-beat incrementing read bursts, and valid/ready handshakes on both request and response. After reset it zero-fills the array with a sweep FSM, one word per cycle, instead of clearing every entry in one cycle. It sits between the fetch unit or bus bridge and on-chip storage, serving both instruction and data fills.

## Interface
- data_size, 32, word width in bits; must be a multiple of 8.
- mem_size, 1024, number of words.
- mem_size_bit, 10, address width; mem_size = 2^mem_size_bit.
- wait_states, 1, extra cycles before the first read beat; range 0..7.
- burst_bit, 2, width of the burst-length field; maximum burst is 2^burst_bit beats.

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising clock edge.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read burst.
- req_address  in  mem_size_bit  word address; start address for bursts.
- req_burst  in  burst_bit  number of read beats minus 1; ignored for writes.
- req_wdata  in  data_size  write data.
- req_byte_en  in  data_size/8  per-byte write enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  read beat present.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_data  out  data_size  read beat data.
- rsp_last  out  1  marks the final beat of a burst.
- busy  out  1  clear sweep in progress.

## Operation
- The FSM has four states: CLEAR, IDLE, WAIT and BURST.
- **Reset (reset=0):**
  - state goes to CLEAR; clear address goes to 0.
  - Outputs go to req_ready=0, rsp_valid=0, rsp_last=0, rsp_data=0, busy=1.
  - Asserting reset in any state aborts the operation in progress.
- **CLEAR:**
  - Each edge with reset=1 writes 0 to mem[clr_addr] and increments clr_addr.
  - The edge that writes index mem_size-1 moves the FSM to IDLE and drops busy.
  - req_ready=0 throughout.
- **IDLE:**
  - req_ready=1.
  - A write accepted at edge k updates only the enabled bytes of mem[req_address] at edge k. All-zero byte_en leaves the word unchanged.
  - A write produces no response. The FSM stays in IDLE, so back-to-back writes are accepted every cycle.
  - A read accepted at edge k latches the address, the beat count (req_burst+1) and a wait counter of wait_states, then moves to WAIT.
- **WAIT:**
  - req_ready=0.
  - Each edge with a non-zero counter decrements it.
  - The edge at which the counter is 0 loads rsp_data<=mem[addr], sets rsp_valid=1, sets rsp_last=(beats==1) and moves to BURST.
- **BURST:**
  - req_ready=0. rsp_data, rsp_valid and rsp_last hold stable while rsp_ready=0.
  - On an edge with rsp_ready=1 and rsp_last=0: addr<=addr+1, with wrap from mem_size-1 to 0. rsp_data loads the next word and the remaining-beat count decrements.
  - On an edge with rsp_ready=1 and rsp_last=1: rsp_valid<=0, rsp_last<=0 and the FSM returns to IDLE.
- A request offered while req_ready=0 is not consumed; the requester holds it.
- Address arithmetic is modulo 2^mem_size_bit. The beat counter is burst_bit+1 bits wide.

## Timing
- **Read latency:** a read accepted at edge k presents its first beat after edge k+1+wait_states.
  - wait_states=0 gives a 1-cycle read.
  - wait_states=1 gives first data after edge k+2.
- **Burst throughput:** one beat per cycle while rsp_ready=1.
- **Turnaround:** req_ready rises in the cycle after the last beat is accepted. Total occupancy of a zero-stall burst is 1+wait_states+beats cycles.
- **Read-after-write:** a write at edge k followed by a read accepted at edge k+1 returns the new data.
- **Clear:** busy stays high for exactly mem_size cycles after the first edge with reset=1. req_ready first rises in the cycle after the last clear write.
- **Reset re-asserted mid-CLEAR:** the sweep restarts from address 0.
- **Reset mid-burst:** rsp_valid drops at that edge and the memory is re-cleared.

## Test plan
- Release reset and hold 0 for mem_size cycles. Required: busy=1 for exactly 1024 cycles (defaults), then req_ready=1; a read of address 5 returns 0.
- Write 0xDEADBEEF to address 3 with byte_en=4'b1111, then write 0x000000AA with byte_en=4'b0001, then read address 3. Required: rsp_data=0xDEADBEAA and rsp_last=1, with rsp_valid first high 2 cycles after acceptance (wait_states=1).
- Write 0x11, 0x22, 0x33, 0x44 to addresses 1022, 1023, 0, 1, then issue a read burst at 1022 with req_burst=3 and rsp_ready=1. Required: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, rsp_last only on 0x44, req_ready high the cycle after.
- Run the same burst with rsp_ready toggling 1,0,0,1,1,0,1. Required: each beat is held stable while stalled, with no beat lost or duplicated.
- Pull reset low for one cycle during beat 2 of a 4-beat burst. Required: rsp_valid=0 at the next edge, busy=1, and all previously written words read back as 0 after the clear.
- Hold req_valid high during WAIT and BURST. Required: the request is not accepted until IDLE, then accepted exactly once.
